// File: rtl/int_injector.sv
// Interrupt stimulus generator: raises a level interrupt when the CPU's architectural PC
// hits an armed trigger slot, holds it until a response store or timeout, then cools down.
module int_injector #(
    parameter int          NUM_TRIG = 4,
    parameter logic [31:0] ACK_ADDR = 32'h0000_7F20,
    parameter logic [15:0] TIMEOUT  = 16'd1000,
    parameter logic [3:0]  COOLDOWN = 4'd3,
    localparam int         IDX_W    = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      macroscopic_pc,
    input  logic [31:0]      m_int_addr,
    input  logic [3:0]       m_int_byteen,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [31:0]      cfg_pc,
    input  logic             cfg_en,
    output logic             interrupt,
    output logic [7:0]       int_count,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        COOL   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   hold_cnt_q, hold_cnt_d;
    logic [3:0]    cool_cnt_q, cool_cnt_d;
    logic          interrupt_q, interrupt_d;
    logic [7:0]    int_count_q, int_count_d;
    logic          timeout_q, timeout_d;

    logic [NUM_TRIG-1:0] slot_match;
    logic                any_match;
    logic                ack;
    logic                hold_done;
    logic                unused_low_bits;

    // Word-granular compares throughout; the byte-offset bits carry no meaning here.
    assign unused_low_bits = ^{macroscopic_pc[1:0], m_int_addr[1:0], cfg_pc[1:0]};

    assign ack       = (|m_int_byteen) && (m_int_addr[31:2] == ACK_ADDR[31:2]);
    assign any_match = |slot_match;
    assign hold_done = ({1'b0, hold_cnt_q} + 17'd1) >= {1'b0, TIMEOUT};

    generate
        for (genvar gi = 0; gi < NUM_TRIG; gi++) begin : g_slot
            logic [29:0] pc_q, pc_d;
            logic        en_q, en_d;
            logic        fired_q, fired_d;
            logic        wr;

            // A write to this slot masks its match so the new contents are judged next cycle.
            assign wr = cfg_we && (cfg_idx == IDX_W'(gi));
            assign slot_match[gi] = en_q && !fired_q && !wr &&
                                    (pc_q == macroscopic_pc[31:2]);

            always_comb begin
                pc_d    = pc_q;
                en_d    = en_q;
                fired_d = fired_q;
                if (wr) begin
                    pc_d    = cfg_pc[31:2];
                    en_d    = cfg_en;
                    fired_d = 1'b0;
                end else if (state_q == IDLE && slot_match[gi]) begin
                    fired_d = 1'b1;
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    pc_q    <= '0;
                    en_q    <= 1'b0;
                    fired_q <= 1'b0;
                end else begin
                    pc_q    <= pc_d;
                    en_q    <= en_d;
                    fired_q <= fired_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            cool_cnt_q  <= '0;
            interrupt_q <= 1'b0;
            int_count_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            cool_cnt_q  <= cool_cnt_d;
            interrupt_q <= interrupt_d;
            int_count_q <= int_count_d;
            timeout_q   <= timeout_d;
        end
    end

    // With no cooldown the release goes straight back to IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_match) state_d = ASSERT;
            ASSERT:  if (ack || hold_done) state_d = (COOLDOWN == 4'd0) ? IDLE : COOL;
            COOL:    if (cool_cnt_q == COOLDOWN - 4'd1) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        cool_cnt_d  = cool_cnt_q;
        interrupt_d = interrupt_q;
        int_count_d = int_count_q;
        timeout_d   = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (any_match) begin
                    interrupt_d = 1'b1;
                    hold_cnt_d  = '0;
                end
            end
            ASSERT: begin
                hold_cnt_d = hold_cnt_q + 16'd1;
                if (ack) begin
                    interrupt_d = 1'b0;
                    cool_cnt_d  = '0;
                    if (int_count_q != 8'hFF) int_count_d = int_count_q + 8'd1;
                end else if (hold_done) begin
                    interrupt_d = 1'b0;
                    timeout_d   = 1'b1;
                    cool_cnt_d  = '0;
                end
            end
            COOL:    cool_cnt_d = cool_cnt_q + 4'd1;
            default: ;
        endcase
    end

    assign interrupt = interrupt_q;
    assign int_count = int_count_q;
    assign timeout   = timeout_q;

endmodule

// File: doc/int_injector.md
# int_injector

Interrupt stimulus generator for the P7 CPU testbench: drives the CPU `interrupt` input and consumes the CPU's `macroscopic_pc`, `m_int_addr` and `m_int_byteen` outputs. It raises a level interrupt when the architectural PC reaches a programmed trigger address. It holds the interrupt until the handler acknowledges it with a store to the response address, or until a timeout expires. It sits beside the `mips` instance in the bench, directly upstream of the CPU interrupt input.

## Interface
- `NUM_TRIG`, 4: number of trigger slots; must be at least 1.
- `ACK_ADDR`, 32'h0000_7F20: interrupt-response word address; bits [1:0] are ignored.
- `TIMEOUT`, 16'd1000: cycles `interrupt` may stay high without an ack.
- `COOLDOWN`, 4'd3: cycles after deassertion before a new trigger is accepted.
- `clk` in 1: clock, rising-edge.
- `reset` in 1: asynchronous, active-low reset.
- `macroscopic_pc` in 32: CPU architectural PC.
- `m_int_addr` in 32: CPU interrupt-response store address.
- `m_int_byteen` in 4: CPU interrupt-response store byte enables.
- `cfg_we` in 1: slot write strobe.
- `cfg_idx` in max(1,$clog2(NUM_TRIG)): slot index.
- `cfg_pc` in 32: trigger PC written to the slot; bits [1:0] are ignored.
- `cfg_en` in 1: slot enable written with the PC.
- `interrupt` out 1: to the CPU.
- `int_count` out 8: number of acknowledged interrupts, saturating at 255.
- `timeout` out 1: sticky flag, set when an interrupt was dropped without an ack.

## Operation
- Per-slot state: `pc[31:2]`, `en`, and `fired`. Reset clears all three fields in every slot.
- Slot write: `cfg_we` loads `pc` and `en` at `slot[cfg_idx]` and clears that slot's `fired`. An out-of-range `cfg_idx` is ignored.
- Slot match: `en && !fired && pc == macroscopic_pc[31:2]`.
- Ack: `|m_int_byteen && m_int_addr[31:2] == ACK_ADDR[31:2]`.
- FSM states are IDLE, ASSERT and COOL.
  - IDLE: if any slot matches, go to ASSERT, set `fired` on every matching slot, and set `interrupt`=1. Any ack received in IDLE is ignored and not counted.
  - ASSERT: hold `interrupt`=1 and increment the hold counter.
    - On ack: set `interrupt`=0, increment `int_count` (saturating at 255), go to COOL.
    - If the hold counter reaches `TIMEOUT` with no ack: set `interrupt`=0, set `timeout`=1, go to COOL.
    - If ack and timeout occur in the same cycle, the ack wins: `timeout` is unchanged and the count increments.
    - Matches occurring in ASSERT are not latched. The affected slots stay armed.
  - COOL: count `COOLDOWN` cycles, then go to IDLE. When `COOLDOWN`=0, go to IDLE on the next cycle.
  - No state other than IDLE starts a new assertion.
- A slot write to a slot that matches in the same cycle: the write wins, the slot does not fire that cycle, and it is re-evaluated from the next cycle.
- A slot write during ASSERT or COOL does not affect the interrupt currently in progress.
- `timeout` is cleared only by reset.
- The hold counter is 16 bits and clears on entry to ASSERT. The cooldown counter is 4 bits.

## Timing
- All outputs are registered.
- Reset values: `interrupt`=0, `int_count`=0, `timeout`=0, state IDLE, all slots cleared.
- Reset asserted mid-operation clears everything immediately and asynchronously. `interrupt` drops without waiting for a clock edge.
- Trigger latency: a match sampled at edge N gives `interrupt`=1 after edge N.
- Ack latency: an ack sampled at edge M gives `interrupt`=0 and the incremented `int_count` after edge M.
- Interrupt width: with the ack first sampled k edges after assertion, `interrupt` is high for exactly k cycles.
- Timeout: `interrupt` is high for exactly `TIMEOUT` cycles, then `timeout`=1 after the same edge that drops `interrupt`.
- Rearm gap: the earliest new assertion is `COOLDOWN`+1 edges after deassertion.

## Test plan
- Reset, then program slot0=32'h3010 with en=1, then run the PC through 32'h3010 → `interrupt` rises after the edge sampling 32'h3010. Ack with `m_int_addr`=32'h7F20 and byteen=4'b0001 three cycles later → `interrupt` was high for 3 cycles and `int_count`=1.
- Program slot0=32'h3020 and never ack, with TIMEOUT=1000 → `interrupt` stays high for exactly 1000 cycles, then `timeout`=1 and `int_count`=0. The PC revisiting 32'h3020 does not retrigger.
- Program slot0=32'h3030 and slot1=32'h3040. The PC hits 32'h3040 while slot0's interrupt is in ASSERT → no second assertion. After ack and the 3-cycle cooldown, the PC hitting 32'h3040 again fires → `int_count`=2.
- Send an ack with `m_int_addr`=32'h7F20 while IDLE, and an ack with 32'h7F24 while in ASSERT → neither has any effect; `int_count` is unchanged and `interrupt` stays as it was.
- In the same cycle, write slot0 and have the PC match slot0's old value → no fire. The next-cycle match against the new PC value fires normally.
- Assert reset while `interrupt`=1 → `interrupt` is 0 before the next clock edge, and all slots are disabled.
